// File: rtl/data_mem_responder.sv
// data_mem_responder: word-organised data memory behind valid/ready
// request and response channels, with programmable wait states.
//
// Ports:
//   Clk       rising-edge clock
//   Rst       synchronous active-high reset (state only, not memory)
//   ReqValid  request present
//   ReqWrite  1 = store, 0 = load
//   ReqAddr   byte address
//   ReqWData  store data
//   ReqReady  responder is idle and can take a request
//   RspValid  response present
//   RspReady  requester takes the response
//   RspRData  load data (0 for stores and errors)
//   RspErr    misaligned or out-of-range request
module data_mem_responder #(
   parameter int DEPTH_LOG2  = 8,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        Clk,
   input  logic        Rst,
   input  logic        ReqValid,
   input  logic        ReqWrite,
   input  logic [31:0] ReqAddr,
   input  logic [31:0] ReqWData,
   output logic        ReqReady,
   output logic        RspValid,
   input  logic        RspReady,
   output logic [31:0] RspRData,
   output logic        RspErr
);

   localparam int DEPTH = 1 << DEPTH_LOG2;

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_RESP
   } state_t;

   state_t state;
   state_t state_nxt;

   logic [3:0]  cnt;
   logic        wr_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [31:0] rdata_q;
   logic        err_q;

   logic [31:0] mem [DEPTH];

   logic                  accept;
   logic                  access;
   logic                  done;
   logic                  bad;
   logic [DEPTH_LOG2-1:0] idx;

   assign accept = (state == S_IDLE) && ReqValid;
   // The access cycle is the last WAIT cycle (counter at zero), so the
   // response appears WAIT_CYCLES+1 edges after acceptance.
   assign access = (state == S_WAIT) && (cnt == 4'd0);
   assign done   = (state == S_RESP) && RspReady;

   assign idx = addr_q[DEPTH_LOG2+1:2];
   // Upper address bits must be zero: no aliasing onto the array.
   assign bad = (addr_q[1:0] != 2'b00)
             || (addr_q[31:DEPTH_LOG2+2] != '0);

   // State register and wait counter
   always_ff @(posedge Clk) begin
      if (Rst) begin
         state <= S_IDLE;
         cnt   <= 4'd0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            cnt <= 4'(WAIT_CYCLES);
         end else if ((state == S_WAIT) && (cnt != 4'd0)) begin
            cnt <= cnt - 4'd1;
         end
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE: if (ReqValid) state_nxt = S_WAIT;
         S_WAIT: if (cnt == 4'd0) state_nxt = S_RESP;
         S_RESP: if (RspReady) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      ReqReady = (state == S_IDLE);
      RspValid = (state == S_RESP);
      RspRData = rdata_q;
      RspErr   = err_q;
   end

   // Request capture; held stable until the access edge
   always_ff @(posedge Clk) begin
      if (accept && !Rst) begin
         wr_q    <= ReqWrite;
         addr_q  <= ReqAddr;
         wdata_q <= ReqWData;
      end
   end

   // Response registers
   always_ff @(posedge Clk) begin
      if (Rst) begin
         rdata_q <= 32'd0;
         err_q   <= 1'b0;
      end else if (access) begin
         err_q   <= bad;
         rdata_q <= (wr_q || bad) ? 32'd0 : mem[idx];
      end else if (done) begin
         rdata_q <= 32'd0;
         err_q   <= 1'b0;
      end
   end

   // Single-port array; reset gates the write so an uncommitted store
   // is dropped, but contents are never cleared.
   always_ff @(posedge Clk) begin
      if (!Rst && access && wr_q && !bad) begin
         mem[idx] <= wdata_q;
      end
   end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed vectors plus hand-written sequences
// for a default build and a zero-wait-state build.
module tb_data_mem_responder;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic        a_req_valid, a_req_write, a_req_ready;
   logic [31:0] a_req_addr, a_req_wdata;
   logic        a_rsp_valid, a_rsp_ready, a_rsp_err;
   logic [31:0] a_rsp_rdata;

   logic        b_req_valid, b_req_write, b_req_ready;
   logic [31:0] b_req_addr, b_req_wdata;
   logic        b_rsp_valid, b_rsp_ready, b_rsp_err;
   logic [31:0] b_rsp_rdata;

   data_mem_responder #(.DEPTH_LOG2(8), .WAIT_CYCLES(2)) ua (
      .Clk(clk), .Rst(rst),
      .ReqValid(a_req_valid), .ReqWrite(a_req_write),
      .ReqAddr(a_req_addr), .ReqWData(a_req_wdata),
      .ReqReady(a_req_ready), .RspValid(a_rsp_valid),
      .RspReady(a_rsp_ready), .RspRData(a_rsp_rdata),
      .RspErr(a_rsp_err)
   );

   data_mem_responder #(.DEPTH_LOG2(8), .WAIT_CYCLES(0)) ub (
      .Clk(clk), .Rst(rst),
      .ReqValid(b_req_valid), .ReqWrite(b_req_write),
      .ReqAddr(b_req_addr), .ReqWData(b_req_wdata),
      .ReqReady(b_req_ready), .RspValid(b_rsp_valid),
      .RspReady(b_rsp_ready), .RspRData(b_rsp_rdata),
      .RspErr(b_rsp_err)
   );

   logic        sel = 1'b0;
   logic        c_req_ready, c_rsp_valid, c_rsp_err;
   logic [31:0] c_rsp_rdata;
   assign c_req_ready = sel ? b_req_ready : a_req_ready;
   assign c_rsp_valid = sel ? b_rsp_valid : a_rsp_valid;
   assign c_rsp_err   = sel ? b_rsp_err   : a_rsp_err;
   assign c_rsp_rdata = sel ? b_rsp_rdata : a_rsp_rdata;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      string       name;
      logic        write;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          lat;
      logic [31:0] rdata;
      logic        err;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic set_req(input logic v, input logic w,
                          input logic [31:0] a, input logic [31:0] d);
      if (sel) begin
         b_req_valid = v; b_req_write = w;
         b_req_addr = a;  b_req_wdata = d;
      end else begin
         a_req_valid = v; a_req_write = w;
         a_req_addr = a;  a_req_wdata = d;
      end
   endtask

   task automatic set_rdy(input logic r);
      if (sel) b_rsp_ready = r;
      else     a_rsp_ready = r;
   endtask

   // Issue a request, wait (bounded) for the response, handshake it.
   // lat counts edges from acceptance to first visible RspValid.
   task automatic txn(input string nm, input logic w,
                      input logic [31:0] a, input logic [31:0] d,
                      output int lat, output logic [31:0] rd,
                      output logic er);
      @(negedge clk);
      chk({nm, ".req_ready"}, 32'(c_req_ready), 32'd1);
      set_req(1'b1, w, a, d);
      @(negedge clk);
      set_req(1'b0, 1'b0, 32'd0, 32'd0);
      lat = 0;
      while (!c_rsp_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      rd = c_rsp_rdata;
      er = c_rsp_err;
      set_rdy(1'b1);
      @(negedge clk);
      set_rdy(1'b0);
      chk({nm, ".post_flags"},
          {29'd0, c_rsp_valid, c_req_ready, c_rsp_err}, 32'd2);
      chk({nm, ".post_rdata"}, c_rsp_rdata, 32'd0);
   endtask

   task automatic add(input string nm, input logic w,
                      input logic [31:0] a, input logic [31:0] d,
                      input int lat, input logic [31:0] rd,
                      input logic er);
      vec_t v;
      v.name = nm; v.write = w; v.addr = a; v.wdata = d;
      v.lat = lat; v.rdata = rd; v.err = er;
      vecs.push_back(v);
   endtask

   initial begin
      int          lat;
      logic [31:0] rd;
      logic        er;
      int          k;

      add("st10",     1, 32'h10,       32'hDEADBEEF, 3, 32'h0, 0);
      add("ld10",     0, 32'h10,       32'h0,        3, 32'hDEADBEEF, 0);
      add("st_mis",   1, 32'h12,       32'h12345678, 3, 32'h0, 1);
      add("ld_oor",   0, 32'h400,      32'h0,        3, 32'h0, 1);
      add("ld10_b",   0, 32'h10,       32'h0,        3, 32'hDEADBEEF, 0);
      add("st_alias", 1, 32'h80000010, 32'hBAD0BAD0, 3, 32'h0, 1);
      add("ld10_c",   0, 32'h10,       32'h0,        3, 32'hDEADBEEF, 0);
      add("st3fc",    1, 32'h3FC,      32'hA5A5A5A5, 3, 32'h0, 0);
      add("ld3fc",    0, 32'h3FC,      32'h0,        3, 32'hA5A5A5A5, 0);
      add("st20_0",   1, 32'h20,       32'h0,        3, 32'h0, 0);
      add("ld_mis",   0, 32'h3,        32'h0,        3, 32'h0, 1);

      a_rsp_ready = 0; b_rsp_ready = 0;
      sel = 0; set_req(0, 0, 0, 0);
      sel = 1; set_req(0, 0, 0, 0);
      sel = 0;

      repeat (3) @(negedge clk);
      rst = 0;
      chk("rst.req_ready", 32'(a_req_ready), 32'd1);
      chk("rst.rsp_valid", 32'(a_rsp_valid), 32'd0);
      chk("rst.rsp_rdata", a_rsp_rdata, 32'd0);
      chk("rst.rsp_err",   32'(a_rsp_err), 32'd0);

      foreach (vecs[i]) begin
         txn(vecs[i].name, vecs[i].write, vecs[i].addr, vecs[i].wdata,
             lat, rd, er);
         chk({vecs[i].name, ".lat"}, 32'(lat), 32'(vecs[i].lat));
         chk({vecs[i].name, ".rdata"}, rd, vecs[i].rdata);
         chk({vecs[i].name, ".err"}, 32'(er), 32'(vecs[i].err));
      end

      // Backpressure: hold RspReady low, inject an ignored request.
      @(negedge clk);
      set_req(1, 0, 32'h10, 32'h0);
      @(negedge clk);
      set_req(0, 0, 0, 0);
      k = 0;
      while (!a_rsp_valid && k < 20) begin
         @(negedge clk);
         k++;
      end
      chk("bp.lat", 32'(k), 32'd3);
      for (int c = 0; c < 5; c++) begin
         if (c == 1) set_req(1, 1, 32'h10, 32'h0BADF00D);
         else        set_req(0, 0, 0, 0);
         @(negedge clk);
         chk("bp.flags", {30'd0, a_rsp_valid, a_req_ready}, 32'd2);
         chk("bp.rdata", a_rsp_rdata, 32'hDEADBEEF);
      end
      set_req(0, 0, 0, 0);
      a_rsp_ready = 1;
      @(negedge clk);
      a_rsp_ready = 0;
      chk("bp.ready_after", 32'(a_req_ready), 32'd1);
      repeat (5) @(negedge clk);
      chk("bp.no_ghost", 32'(a_rsp_valid), 32'd0);
      txn("bp_ld", 0, 32'h10, 32'h0, lat, rd, er);
      chk("bp_ld.rdata", rd, 32'hDEADBEEF);

      // Reset in the first WAIT cycle discards the store.
      @(negedge clk);
      set_req(1, 1, 32'h20, 32'h55AA55AA);
      @(negedge clk);
      set_req(0, 0, 0, 0);
      rst = 1;
      @(negedge clk);
      rst = 0;
      chk("rw.flags", {30'd0, a_rsp_valid, a_req_ready}, 32'd1);
      repeat (5) @(negedge clk);
      chk("rw.no_rsp", 32'(a_rsp_valid), 32'd0);
      txn("rw_ld", 0, 32'h20, 32'h0, lat, rd, er);
      chk("rw_ld.rdata", rd, 32'h0);
      chk("rw_ld.lat", 32'(lat), 32'd3);

      // Reset in RESP (with RspReady) drops the response, keeps store.
      @(negedge clk);
      set_req(1, 1, 32'h30, 32'h11112222);
      @(negedge clk);
      set_req(0, 0, 0, 0);
      k = 0;
      while (!a_rsp_valid && k < 20) begin
         @(negedge clk);
         k++;
      end
      chk("rr.lat", 32'(k), 32'd3);
      rst = 1; a_rsp_ready = 1;
      @(negedge clk);
      rst = 0; a_rsp_ready = 0;
      chk("rr.flags", {30'd0, a_rsp_valid, a_req_ready}, 32'd1);
      txn("rr_ld", 0, 32'h30, 32'h0, lat, rd, er);
      chk("rr_ld.rdata", rd, 32'h11112222);

      // Zero-wait-state build, top word.
      sel = 1;
      txn("z_st", 1, 32'h3FC, 32'hCAFEF00D, lat, rd, er);
      chk("z_st.lat", 32'(lat), 32'd1);
      chk("z_st.err", 32'(er), 32'd0);
      txn("z_ld", 0, 32'h3FC, 32'h0, lat, rd, er);
      chk("z_ld.lat", 32'(lat), 32'd1);
      chk("z_ld.rdata", rd, 32'hCAFEF00D);
      chk("z_ld.err", 32'(er), 32'd0);
      txn("z_oor", 0, 32'h400, 32'h0, lat, rd, er);
      chk("z_oor.err", 32'(er), 32'd1);
      chk("z_oor.rdata", rd, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
